alu_frame_controller: RTL

- Framed, checksummed command sequencer between the UART FIFOs and the ALU, with inter-byte timeout and error reporting.
- Pops request frames [SOF, opcode, A, B, CHK] from the UART RX FIFO and validates them.
- Drives the ALU operands and opcode, captures the result, and pushes a response frame [RSP, result, status] to the UART TX FIFO.
- Sits in the top level in place of the plain UART/ALU interface; the UART and ALU instances are unchanged.

---
 rtl/alu_frame_controller.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_frame_controller.sv
// alu_frame_controller
//   Framed, checksummed command sequencer between the UART FIFOs and the ALU.
//   Request frame  : [SOF, opcode, A, B, CHK] with CHK = opcode ^ A ^ B
//   Response frame : [RSP, result, status]
//   Status codes   : 0x00 ok, 0x01 bad checksum, 0x02 inter-byte timeout,
//                    0x03 reserved opcode bits set.
//
// Ports
//   clk, reset          : system clock, asynchronous active-high reset
//   r_data, rx_empty    : RX FIFO head byte (show-ahead) and empty flag
//   rd_uart             : one-cycle RX pop strobe
//   tx_full             : TX FIFO full
//   w_data, wr_uart     : TX byte and one-cycle push strobe
//   result              : combinational ALU result
//   op_code, data_a/b   : registered ALU opcode and operands
//   o_busy              : high whenever the sequencer is not in IDLE
//   o_frame_cnt         : good-frame count (wraps)
//   o_err_cnt           : error-frame count (saturates at 255)
module alu_frame_controller #(
  parameter int          DBIT        = 8,
  parameter int          NB_OP       = 6,
  parameter int          NB_AB       = 8,
  parameter logic [7:0]  SOF         = 8'hA5,
  parameter logic [7:0]  RSP         = 8'h5A,
  parameter int          NB_TO       = 16,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBIT-1:0]  r_data,
  input  logic             rx_empty,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [DBIT-1:0]  w_data,
  output logic             wr_uart,
  input  logic [NB_AB-1:0] result,
  output logic [NB_OP-1:0] op_code,
  output logic [NB_AB-1:0] data_a,
  output logic [NB_AB-1:0] data_b,
  output logic             o_busy,
  output logic [7:0]       o_frame_cnt,
  output logic [7:0]       o_err_cnt
);

  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [NB_TO-1:0] TO_LAST = NB_TO'(TIMEOUT_CYC - 1);

  localparam logic [DBIT-1:0] STS_OK  = DBIT'(8'h00);
  localparam logic [DBIT-1:0] STS_CHK = DBIT'(8'h01);
  localparam logic [DBIT-1:0] STS_TO  = DBIT'(8'h02);
  localparam logic [DBIT-1:0] STS_OPC = DBIT'(8'h03);

  typedef enum logic [3:0] {
    IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, SEND_HDR, SEND_RES, SEND_STS
  } state_t;

  state_t           state;
  logic [DBIT-1:0]  op_byte;
  logic [DBIT-1:0]  a_byte;
  logic [DBIT-1:0]  b_byte;
  logic [DBIT-1:0]  sts;
  logic [NB_AB-1:0] res_q;
  logic [NB_TO-1:0] to_cnt;

  logic             rx_phase;
  logic             get_phase;
  logic             send_phase;
  logic             to_expire;
  logic [DBIT-1:0]  chk_sts;

  // Checksum mismatch outranks the reserved-opcode check.
  function automatic logic [DBIT-1:0] frame_status(
    input logic [DBIT-1:0] op, input logic [DBIT-1:0] a,
    input logic [DBIT-1:0] b,  input logic [DBIT-1:0] chk);
    if (chk != (op ^ a ^ b))        return STS_CHK;
    else if (op[DBIT-1:NB_OP] != '0) return STS_OPC;
    else                             return STS_OK;
  endfunction

  assign get_phase  = (state == GET_OP) || (state == GET_A) ||
                      (state == GET_B)  || (state == GET_CHK);
  assign rx_phase   = (state == IDLE) || get_phase;
  assign send_phase = (state == SEND_HDR) || (state == SEND_RES) ||
                      (state == SEND_STS);

  // Pop/push strobes follow the FIFO flags in the same cycle so a byte is
  // consumed or produced exactly once; reset forces them low.
  assign rd_uart = rx_phase && !rx_empty && !reset;
  assign wr_uart = send_phase && !tx_full && !reset;
  assign o_busy  = (state != IDLE);

  // The counter has already seen TO_LAST idle cycles; this idle cycle
  // is the one that makes it reach TIMEOUT_CYC.
  assign to_expire = TO_EN && get_phase && rx_empty && (to_cnt == TO_LAST);

  assign chk_sts = frame_status(op_byte, a_byte, b_byte, r_data);

  always_comb begin
    w_data = '0;
    case (state)
      SEND_HDR: w_data = DBIT'(RSP);
      SEND_RES: w_data = DBIT'(res_q);
      SEND_STS: w_data = sts;
      default:  w_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_byte     <= '0;
      a_byte      <= '0;
      b_byte      <= '0;
      sts         <= '0;
      res_q       <= '0;
      to_cnt      <= '0;
      op_code     <= '0;
      data_a      <= '0;
      data_b      <= '0;
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      // Inter-byte timeout while waiting inside a frame.
      if (get_phase && !rd_uart) begin
        if (to_expire) begin
          sts    <= STS_TO;
          res_q  <= '0;
          to_cnt <= '0;
          state  <= SEND_HDR;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (rd_uart && (r_data == DBIT'(SOF))) begin
            to_cnt <= '0;
            state  <= GET_OP;
          end
        end
        GET_OP: begin
          if (rd_uart) begin
            op_byte <= r_data;
            to_cnt  <= '0;
            state   <= GET_A;
          end
        end
        GET_A: begin
          if (rd_uart) begin
            a_byte <= r_data;
            to_cnt <= '0;
            state  <= GET_B;
          end
        end
        GET_B: begin
          if (rd_uart) begin
            b_byte <= r_data;
            to_cnt <= '0;
            state  <= GET_CHK;
          end
        end
        GET_CHK: begin
          if (rd_uart) begin
            to_cnt <= '0;
            sts    <= chk_sts;
            if (chk_sts == STS_OK) begin
              // Operands only change on frames that will execute.
              op_code <= op_byte[NB_OP-1:0];
              data_a  <= NB_AB'(a_byte);
              data_b  <= NB_AB'(b_byte);
              state   <= EXEC;
            end else begin
              res_q <= '0;
              state <= SEND_HDR;
            end
          end
        end
        // ---- ALU settles during the cycle after the operand load ----
        EXEC: begin
          res_q <= result;
          state <= SEND_HDR;
        end
        SEND_HDR: if (wr_uart) state <= SEND_RES;
        SEND_RES: if (wr_uart) state <= SEND_STS;
        SEND_STS: begin
          if (wr_uart) begin
            if (sts == STS_OK)
              o_frame_cnt <= o_frame_cnt + 8'd1;
            else if (o_err_cnt != 8'hFF)
              o_err_cnt <= o_err_cnt + 8'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
